// File: rtl/serial_subtractor_8bit_if.sv
// Operand/result bundle for the bit-serial subtractor.
//   master : issues start/a/b/bin, observes diff/bout/busy/done
//   slave  : the subtractor itself
interface serial_subtractor_8bit_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  modport master (output start, a, b, bin, input diff, bout, busy, done);
  modport slave  (input start, a, b, bin, output diff, bout, busy, done);
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^N), one bit per clock,
// LSB first.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of serial_subtractor_8bit_if
//          start/a/b/bin in (operands sampled only when start is accepted in IDLE)
//          diff/bout out (valid on done, held until next accepted start)
//          busy (RUN only), done (one-cycle pulse, N clocks after accept)

module serial_subtractor_8bit_mux4 (
  input  logic [1:0] sel,
  input  logic [3:0] d,
  output logic       y
);
  assign y = d[sel];
endmodule

module serial_subtractor_8bit #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_8bit_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic a0, b0, d_bit, bor_bit;
  assign a0 = a_q[0];
  assign b0 = b_q[0];

  // One-bit full subtractor as two muxes selected by {br,a0}.
  // Index order of d[] is sel 11,10,01,00.
  serial_subtractor_8bit_mux4 u_diff_mux (
    .sel ({br_q, a0}),
    .d   ({b0, ~b0, ~b0, b0}),
    .y   (d_bit)
  );

  serial_subtractor_8bit_mux4 u_borrow_mux (
    .sel ({br_q, a0}),
    .d   ({b0, 1'b1, 1'b0, b0}),
    .y   (bor_bit)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[N-1:1]};
        br_d  = bor_bit;
        cnt_d = cnt_q + CW'(1);
        // Last bit processed on this edge.
        if (cnt_q == CW'(N-1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // res_q/br_q hold after DONE until the next accept, so they drive the
  // result outputs directly.
  assign bus.diff = res_q;
  assign bus.bout = br_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_8bit_if #(.N(N)) bus ();

  serial_subtractor_8bit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] ed;
    logic         eb;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  task automatic ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         output logic [N-1:0] d, output logic bo);
    longint ai, bi, r;
    ai = longint'(a);
    bi = longint'(b) + longint'(bin);
    r  = ai - bi;
    if (r < 0) r = r + (longint'(1) << N);
    d  = N'(r);
    bo = (ai < bi);
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    chk("busy_done_excl", longint'(bus.busy & bus.done), 0);
    if (bus.done) begin
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", longint'(bus.diff), longint'(e.ed));
        chk("bout", longint'(bus.bout), longint'(e.eb));
        chk("latency", longint'(cyc - e.acc), N);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy && !bus.done) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL wait_idle_timeout: got busy=%0b done=%0b expected idle", bus.busy, bus.done);
  endtask

  // Returns at the negedge after the accepting edge (DUT in RUN).
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic [N-1:0] ed, input logic eb);
    wait_idle();
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    sb.push_back('{a, b, bin, ed, eb, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue_rand();
    logic [N-1:0] a, b, d;
    logic bin, bo;
    a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    ref_sub(a, b, bin, d, bo);
    issue(a, b, bin, d, bo);
  endtask

  initial begin
    int cnt, n0, sz;
    logic [N-1:0] d;
    logic bo;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    #1;
    chk("rst_diff", longint'(bus.diff), 0);
    chk("rst_bout", longint'(bus.bout), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic op, busy length and result hold.
    issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    cnt = 0;
    while (bus.busy && cnt < 100) begin cnt++; @(negedge clk); end
    chk("busy_cycles", cnt, 8);
    repeat (3) @(negedge clk);
    chk("hold_diff", longint'(bus.diff), 8'h1E);
    chk("hold_bout", longint'(bus.bout), 0);

    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    issue(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
    issue(8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);

    // start re-pulse during RUN is ignored.
    wait_idle();
    n0 = done_cyc.size();
    issue(8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0);
    @(negedge clk); @(negedge clk);
    bus.a = 8'h11; bus.b = 8'h22; bus.bin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    @(negedge clk); #1;
    chk("repulse_done_count", done_cyc.size() - n0, 1);

    // Abort after the 4th RUN edge.
    sz = done_cyc.size();
    issue(8'h77, 8'h11, 1'b0, 8'h66, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_done", longint'(bus.done), 0);
    chk("abort_diff", longint'(bus.diff), 0);
    chk("abort_bout", longint'(bus.bout), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_no_done", done_cyc.size() - sz, 0);
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // start held high: three back-to-back operations.
    wait_idle();
    n0 = done_cyc.size();
    bus.a = 8'h33; bus.b = 8'h44; bus.bin = 1'b1; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{8'h33, 8'h44, 1'b1, 8'hEE, 1'b1, cyc + 1 + 10 * k});
    cnt = 0;
    while (done_cyc.size() < n0 + 3 && cnt < 100) begin @(negedge clk); #1; cnt++; end
    bus.start = 1'b0;
    chk("held_done_count", done_cyc.size() - n0, 3);
    if (done_cyc.size() >= n0 + 3) begin
      chk("held_spacing1", done_cyc[n0 + 1] - done_cyc[n0], 10);
      chk("held_spacing2", done_cyc[n0 + 2] - done_cyc[n0 + 1], 10);
    end

    // Random run; operands scrambled during RUN must not matter.
    for (int i = 0; i < 1000; i++) begin
      issue_rand();
      bus.a = N'($urandom); bus.b = N'($urandom); bus.bin = 1'($urandom);
    end
    ref_sub(8'h00, 8'h00, 1'b1, d, bo);
    issue(8'h00, 8'h00, 1'b1, d, bo);

    wait_idle();
    @(negedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
